// File: rtl/ahb_pkg.sv
// AHB-Lite shared definitions: transfer/response encodings, default-slave
// state type and small address helpers used by the decoder/mux.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    // Widest address the region helper handles; narrower buses zero-extend.
    localparam int MAX_AW = 64;

    // Default-slave states: idle/OKAY, first (stalled) and second ERROR cycle.
    typedef enum logic [1:0] {
        DS_OK   = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // Ceiling log2, for sizing indices from counts.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Address falls in a power-of-two region whose base is aligned to its size.
    function automatic logic region_hit(input logic [MAX_AW-1:0] addr,
                                       input logic [MAX_AW-1:0] base,
                                       input logic [MAX_AW-1:0] size);
        return ((addr & ~(size - MAX_AW'(1))) == base);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped transfers with the two-cycle AHB ERROR
// response and keeps a saturating count of how many it has issued.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 hready,
    input  logic                 dflt,
    output logic                 ds_hready,
    output logic [1:0]           ds_hresp,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output ds_state_t            ds_state
);

    // An unmapped address phase is accepted either from idle (when the bus
    // is ready) or straight out of the second ERROR cycle, which is always ready.
    logic enter_err1;
    assign enter_err1 = ((ds_state == DS_OK)   & hready & dflt) |
                        ((ds_state == DS_ERR2) & dflt);

    // State, registered response outputs and the saturating error counter.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ds_state  <= DS_OK;
            ds_hready <= 1'b1;
            ds_hresp  <= HRESP_OKAY;
            err_cnt   <= '0;
        end else begin
            if (enter_err1 && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            case (ds_state)
                DS_OK: begin
                    if (enter_err1) begin
                        ds_state  <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    ds_state  <= DS_ERR2;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    if (enter_err1) begin
                        ds_state  <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end else begin
                        ds_state  <= DS_OK;
                        ds_hready <= 1'b1;
                        ds_hresp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    ds_state  <= DS_OK;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB address decoder and response multiplexer for one master and NUM_SLV
// slaves, with a built-in default slave for unmapped addresses.
//
// Handshake: an address phase (HADDR/HTRANS) is accepted on a rising HCLK
// edge only when HREADY=1; its data phase completes on the first later edge
// where HREADY=1. While HREADY=0 the master must not expect a new address
// to be sampled, and the data-phase select register holds.
module ahb_decoder_mux
    import ahb_pkg::*;
#(
    parameter int NUM_SLV    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = {32'h2000, 32'h1000, 32'h0},
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_SIZE = {3{32'h1000}},
    parameter int ERR_CNT_W  = 8
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    input  logic [ADDR_WIDTH-1:0]           HADDR,
    input  logic [1:0]                      HTRANS,
    output logic [NUM_SLV-1:0]              HSELx,
    input  logic [NUM_SLV*DATA_WIDTH-1:0]   S_HRDATA,
    input  logic [NUM_SLV*2-1:0]            S_HRESP,
    input  logic [NUM_SLV-1:0]              S_HREADYOUT,
    output logic [DATA_WIDTH-1:0]           HRDATA,
    output logic [1:0]                      HRESP,
    output logic                            HREADY,
    output logic [ERR_CNT_W-1:0]            ERR_CNT
);

    logic [NUM_SLV-1:0]    hit;
    logic [NUM_SLV-1:0]    hit_prio;
    logic                  dflt;
    logic [NUM_SLV:0]      sel_a;
    logic [NUM_SLV:0]      sel_d;
    logic [DATA_WIDTH-1:0] rdata_mux;
    logic [1:0]            resp_mux;
    logic                  ready_mux;
    logic                  ds_hready;
    logic [1:0]            ds_hresp;
    ds_state_t             ds_state;

    // Region decode; on overlap the lowest slave index keeps the hit.
    always_comb begin
        logic found;
        found    = 1'b0;
        hit      = '0;
        hit_prio = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            hit[i] = region_hit(MAX_AW'(HADDR),
                                MAX_AW'(SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]),
                                MAX_AW'(SLV_SIZE[i*ADDR_WIDTH +: ADDR_WIDTH]));
            hit_prio[i] = hit[i] & ~found;
            found       = found | hit[i];
        end
    end

    // Only NONSEQ/SEQ select anything; IDLE and BUSY fall to the default bit
    // without raising an error.
    assign HSELx = hit_prio & {NUM_SLV{HTRANS[1]}};
    assign dflt  = ~|hit_prio & HTRANS[1];
    assign sel_a = {~|HSELx, HSELx};

    // Data-phase select follows the accepted address phase and holds on stalls.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_d <= {1'b1, {NUM_SLV{1'b0}}};
        end else if (HREADY) begin
            sel_d <= sel_a;
        end
    end

    // One-hot AND-OR mux of the mapped slaves' responses.
    always_comb begin
        rdata_mux = '0;
        resp_mux  = '0;
        ready_mux = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_d[i]) begin
                rdata_mux = rdata_mux | S_HRDATA[i*DATA_WIDTH +: DATA_WIDTH];
                resp_mux  = resp_mux  | S_HRESP[i*2 +: 2];
                ready_mux = ready_mux | S_HREADYOUT[i];
            end
        end
    end

    assign HRDATA = sel_d[NUM_SLV] ? '0        : rdata_mux;
    assign HRESP  = sel_d[NUM_SLV] ? ds_hresp  : resp_mux;
    assign HREADY = sel_d[NUM_SLV] ? ds_hready : ready_mux;

    ahb_default_slave #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .hready    (HREADY),
        .dflt      (dflt),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp),
        .err_cnt   (ERR_CNT),
        .ds_state  (ds_state)
    );

    // The first ERROR cycle is always a stall seen by the master.
    err1_stalls: assert property (@(posedge HCLK) disable iff (HRESET)
        (ds_state == DS_ERR1) |-> !HREADY);

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: three behavioural slaves with
// programmable wait states, plus a second instance with overlapping regions.
module tb_ahb_decoder_mux;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSELx;
    logic [95:0] S_HRDATA;
    logic [5:0]  S_HRESP;
    logic [2:0]  S_HREADYOUT;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        HREADY;
    logic [7:0]  ERR_CNT;

    logic [2:0]  ov_hselx;
    logic [31:0] ov_hrdata;
    logic [1:0]  ov_hresp;
    logic        ov_hready;
    logic [7:0]  ov_err_cnt;
    logic [2:0]  ov_hreadyout;

    logic [31:0] rd_val0, rd_val1, rd_val2;
    logic        hwrite;
    logic [3:0]  wait_cfg [3];
    logic [3:0]  s_wait [3];
    logic [2:0]  s_dp;
    logic        s_wr;
    int          s2_wr_cnt = 0;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    assign S_HRDATA     = {rd_val2, rd_val1, rd_val0};
    assign S_HRESP      = 6'b0;
    assign ov_hreadyout = 3'b111;

    ahb_decoder_mux dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSELx       (HSELx),
        .S_HRDATA    (S_HRDATA),
        .S_HRESP     (S_HRESP),
        .S_HREADYOUT (S_HREADYOUT),
        .HRDATA      (HRDATA),
        .HRESP       (HRESP),
        .HREADY      (HREADY),
        .ERR_CNT     (ERR_CNT)
    );

    ahb_decoder_mux #(
        .SLV_BASE ({32'h2000, 32'h0000, 32'h0000}),
        .SLV_SIZE ({32'h1000, 32'h2000, 32'h1000})
    ) dut_ov (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSELx       (ov_hselx),
        .S_HRDATA    (S_HRDATA),
        .S_HRESP     (S_HRESP),
        .S_HREADYOUT (ov_hreadyout),
        .HRDATA      (ov_hrdata),
        .HRESP       (ov_hresp),
        .HREADY      (ov_hready),
        .ERR_CNT     (ov_err_cnt)
    );

    // Behavioural slaves: capture select on HREADY, then stall wait_cfg cycles.
    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s_dp <= 3'b0;
            s_wr <= 1'b0;
            for (int i = 0; i < 3; i++) s_wait[i] <= 4'd0;
        end else if (HREADY) begin
            if (s_dp[2] && s_wr) s2_wr_cnt <= s2_wr_cnt + 1;
            s_dp <= HSELx;
            s_wr <= hwrite;
            for (int i = 0; i < 3; i++) s_wait[i] <= HSELx[i] ? wait_cfg[i] : 4'd0;
        end else begin
            for (int i = 0; i < 3; i++) if (s_wait[i] != 4'd0) s_wait[i] <= s_wait[i] - 4'd1;
        end
    end

    always_comb begin
        S_HREADYOUT = 3'b0;
        for (int i = 0; i < 3; i++) S_HREADYOUT[i] = (s_wait[i] == 4'd0);
    end

    task automatic do_reset();
        @(negedge HCLK);
        HTRANS = IDLE;
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge HCLK);
        #1;
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp %h", HRDATA, 32'h0); end
        checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL rst_hresp got %b exp %b", HRESP, 2'b00); end
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rst_hready got %b exp %b", HREADY, 1'b1); end
        checks++; if (HSELx !== 3'b000) begin errors++; $display("FAIL rst_hsel got %b exp %b", HSELx, 3'b000); end
        checks++; if (ERR_CNT !== 8'd0) begin errors++; $display("FAIL rst_errcnt got %0d exp %0d", ERR_CNT, 0); end
        HRESET = 1'b0;
    endtask

    task automatic test_read_mapped();
        @(negedge HCLK);
        HADDR = 32'h0000_1004; HTRANS = NONSEQ; hwrite = 1'b0;
        #1;
        checks++; if (HSELx !== 3'b010) begin errors++; $display("FAIL rd_hsel got %b exp %b", HSELx, 3'b010); end
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rd_addr_ready got %b exp %b", HREADY, 1'b1); end
        @(negedge HCLK);
        HTRANS = IDLE;
        #1;
        checks++; if (HRDATA !== 32'hCAFE_0001) begin errors++; $display("FAIL rd_data got %h exp %h", HRDATA, 32'hCAFE_0001); end
        checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL rd_resp got %b exp %b", HRESP, 2'b00); end
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rd_data_ready got %b exp %b", HREADY, 1'b1); end
    endtask

    task automatic test_wait_states();
        int low;
        int wr0;
        logic done;
        low = 0; done = 1'b0; wr0 = s2_wr_cnt;
        wait_cfg[2] = 4'd3;
        @(negedge HCLK);
        HADDR = 32'h0000_2010; HTRANS = NONSEQ; hwrite = 1'b1;
        #1;
        checks++; if (HSELx !== 3'b100) begin errors++; $display("FAIL ws_hsel got %b exp %b", HSELx, 3'b100); end
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge HCLK);
            HTRANS = IDLE; hwrite = 1'b0;
            #1;
            checks++; if (HRDATA !== 32'h2222_0002) begin errors++; $display("FAIL ws_hold_data got %h exp %h", HRDATA, 32'h2222_0002); end
            if (HREADY === 1'b0) low++;
            else done = 1'b1;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ws_timeout got %b exp %b", done, 1'b1); end
        checks++; if (low != 3) begin errors++; $display("FAIL ws_low_cycles got %0d exp %0d", low, 3); end
        @(negedge HCLK);
        #1;
        checks++; if (s2_wr_cnt - wr0 != 1) begin errors++; $display("FAIL ws_writes got %0d exp %0d", s2_wr_cnt - wr0, 1); end
        wait_cfg[2] = 4'd0;
    endtask

    task automatic test_idle_busy();
        @(negedge HCLK);
        HADDR = 32'h0000_1004; HTRANS = IDLE;
        #1;
        checks++; if (HSELx !== 3'b000) begin errors++; $display("FAIL idle_hsel got %b exp %b", HSELx, 3'b000); end
        HTRANS = BUSY;
        #1;
        checks++; if (HSELx !== 3'b000) begin errors++; $display("FAIL busy_hsel got %b exp %b", HSELx, 3'b000); end
        HADDR = 32'h0000_8000;
        @(negedge HCLK);
        HTRANS = IDLE;
        #1;
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL busy_unmapped_ready got %b exp %b", HREADY, 1'b1); end
        checks++; if (ERR_CNT !== 8'd0) begin errors++; $display("FAIL busy_errcnt got %0d exp %0d", ERR_CNT, 0); end
    endtask

    task automatic test_unmapped();
        @(negedge HCLK);
        HADDR = 32'h0000_8000; HTRANS = NONSEQ;
        #1;
        checks++; if (HSELx !== 3'b000) begin errors++; $display("FAIL um_hsel got %b exp %b", HSELx, 3'b000); end
        @(negedge HCLK);
        HTRANS = IDLE;
        #1;
        checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL um_err1_ready got %b exp %b", HREADY, 1'b0); end
        checks++; if (HRESP !== 2'b01) begin errors++; $display("FAIL um_err1_resp got %b exp %b", HRESP, 2'b01); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL um_hrdata got %h exp %h", HRDATA, 32'h0); end
        @(negedge HCLK);
        #1;
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL um_err2_ready got %b exp %b", HREADY, 1'b1); end
        checks++; if (HRESP !== 2'b01) begin errors++; $display("FAIL um_err2_resp got %b exp %b", HRESP, 2'b01); end
        checks++; if (ERR_CNT !== 8'd1) begin errors++; $display("FAIL um_errcnt got %0d exp %0d", ERR_CNT, 1); end
        @(negedge HCLK);
        #1;
        checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL um_back_ok got %b exp %b", HRESP, 2'b00); end
    endtask

    task automatic test_err_back_to_back();
        do_reset();
        @(negedge HCLK);
        HADDR = 32'h0000_8000; HTRANS = NONSEQ;
        @(negedge HCLK);
        HTRANS = IDLE;
        @(negedge HCLK);
        HADDR = 32'h0000_9000; HTRANS = NONSEQ;
        #1;
        checks++; if (HRESP !== 2'b01 || HREADY !== 1'b1) begin errors++; $display("FAIL b2b_err2 got resp %b ready %b exp resp 01 ready 1", HRESP, HREADY); end
        @(negedge HCLK);
        HADDR = 32'h0000_0004; HTRANS = SEQ;
        #1;
        checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL b2b_second_err1 got %b exp %b", HREADY, 1'b0); end
        checks++; if (ERR_CNT !== 8'd2) begin errors++; $display("FAIL b2b_errcnt got %0d exp %0d", ERR_CNT, 2); end
        @(negedge HCLK);
        #1;
        checks++; if (HRESP !== 2'b01 || HREADY !== 1'b1) begin errors++; $display("FAIL b2b_second_err2 got resp %b ready %b exp resp 01 ready 1", HRESP, HREADY); end
        checks++; if (HSELx !== 3'b001) begin errors++; $display("FAIL b2b_seq_hsel got %b exp %b", HSELx, 3'b001); end
        @(negedge HCLK);
        HTRANS = IDLE;
        #1;
        checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL b2b_seq_resp got %b exp %b", HRESP, 2'b00); end
        checks++; if (HRDATA !== 32'h1111_0000) begin errors++; $display("FAIL b2b_seq_data got %h exp %h", HRDATA, 32'h1111_0000); end
        checks++; if (ERR_CNT !== 8'd2) begin errors++; $display("FAIL b2b_errcnt_end got %0d exp %0d", ERR_CNT, 2); end
    endtask

    task automatic test_overlap();
        @(negedge HCLK);
        HADDR = 32'h0000_0800; HTRANS = NONSEQ;
        #1;
        checks++; if (ov_hselx !== 3'b001) begin errors++; $display("FAIL ov_low_wins got %b exp %b", ov_hselx, 3'b001); end
        HADDR = 32'h0000_1800;
        #1;
        checks++; if (ov_hselx !== 3'b010) begin errors++; $display("FAIL ov_upper got %b exp %b", ov_hselx, 3'b010); end
        @(negedge HCLK);
        HTRANS = IDLE;
        @(negedge HCLK);
    endtask

    task automatic test_reset_mid_error();
        @(negedge HCLK);
        HADDR = 32'h0000_8000; HTRANS = NONSEQ;
        @(negedge HCLK);
        HTRANS = IDLE;
        #1;
        checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL mid_pre_err1 got %b exp %b", HREADY, 1'b0); end
        HRESET = 1'b1;
        #1;
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp %b", HREADY, 1'b1); end
        checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL mid_resp got %b exp %b", HRESP, 2'b00); end
        checks++; if (ERR_CNT !== 8'd0) begin errors++; $display("FAIL mid_errcnt got %0d exp %0d", ERR_CNT, 0); end
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        HADDR = 32'h0000_0010; HTRANS = NONSEQ; hwrite = 1'b0;
        @(negedge HCLK);
        HTRANS = IDLE;
        #1;
        checks++; if (HRESP !== 2'b00 || HREADY !== 1'b1) begin errors++; $display("FAIL mid_post_read got resp %b ready %b exp resp 00 ready 1", HRESP, HREADY); end
        checks++; if (HRDATA !== 32'h1111_0000) begin errors++; $display("FAIL mid_post_data got %h exp %h", HRDATA, 32'h1111_0000); end
    endtask

    task automatic test_saturation();
        int lows;
        lows = 0;
        do_reset();
        @(negedge HCLK);
        HADDR = 32'h0000_8000; HTRANS = NONSEQ;
        for (int k = 0; k < 1000 && lows < 300; k++) begin
            @(negedge HCLK);
            #1;
            if (HREADY === 1'b0) begin
                lows++;
                if (lows == 254) begin
                    checks++; if (ERR_CNT !== 8'd254) begin errors++; $display("FAIL sat_pre got %0d exp %0d", ERR_CNT, 254); end
                end
            end
        end
        HTRANS = IDLE;
        checks++; if (lows != 300) begin errors++; $display("FAIL sat_err_count got %0d exp %0d", lows, 300); end
        repeat (3) @(negedge HCLK);
        #1;
        checks++; if (ERR_CNT !== 8'd255) begin errors++; $display("FAIL sat_errcnt got %0d exp %0d", ERR_CNT, 255); end
        checks++; if (HRESP !== 2'b00 || HREADY !== 1'b1) begin errors++; $display("FAIL sat_idle got resp %b ready %b exp resp 00 ready 1", HRESP, HREADY); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b0;
        HADDR  = 32'h0;
        HTRANS = IDLE;
        hwrite = 1'b0;
        rd_val0 = 32'h1111_0000;
        rd_val1 = 32'hCAFE_0001;
        rd_val2 = 32'h2222_0002;
        for (int i = 0; i < 3; i++) wait_cfg[i] = 4'd0;
        #2 HRESET = 1'b1;

        test_reset();
        test_read_mapped();
        test_wait_states();
        test_idle_busy();
        test_unmapped();
        test_err_back_to_back();
        test_overlap();
        test_reset_mid_error();
        test_saturation();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
